mandelbrot_pixel_dispatcher: RTL and testbench

//  Upstream feeder for the Mandelbrot iteration solver. Walks the screen in raster

---
 rtl/mandelbrot_pixel_dispatcher.sv | 117 +++++++++++
 tb/tb_mandelbrot_pixel_dispatcher.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mandelbrot_pixel_dispatcher.sv
// Mandelbrot pixel dispatcher.
// Walks the screen in raster order and hands one complex coordinate per pixel
// to the iteration solver over a valid/ready handshake.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   S_IDLE | waiting for start; outputs hold their last values, busy=0
//   S_RUN  | presenting pixels; advance only on out_valid & out_ready
//   S_DONE | one cycle after the last accept; frame_done pulses here
module mandelbrot_pixel_dispatcher #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int WIDTH = 27,
    parameter int ITERW = 13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] cr_start,
    input  logic [WIDTH-1:0] ci_start,
    input  logic [WIDTH-1:0] dx,
    input  logic [WIDTH-1:0] dy,
    input  logic [ITERW-1:0] in_max_iter,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] cr,
    output logic [WIDTH-1:0] ci,
    output logic [9:0]       pixel_x,
    output logic [8:0]       pixel_y,
    output logic [ITERW-1:0] out_max_iter,
    output logic             busy,
    output logic             frame_done
);

    localparam logic [9:0] X_LAST = 10'(H_RES - 1);
    localparam logic [8:0] Y_LAST = 9'(V_RES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_cr_start;
    logic [WIDTH-1:0] r_dx;
    logic [WIDTH-1:0] r_dy;
    logic             w_handshake;

    // The handshake depends only on registered valid and the downstream ready.
    assign w_handshake = out_valid & out_ready;

    // Frame sequencer: latches the frame setup, steps the raster walk and
    // owns every output register.  cr is reloaded from the latched start at
    // each row restart so column-step error never carries to the next row.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_cr_start   <= '0;
            r_dx         <= '0;
            r_dy         <= '0;
            out_valid    <= 1'b0;
            cr           <= '0;
            ci           <= '0;
            pixel_x      <= '0;
            pixel_y      <= '0;
            out_max_iter <= '0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    frame_done <= 1'b0;
                    if (start) begin
                        r_cr_start   <= cr_start;
                        r_dx         <= dx;
                        r_dy         <= dy;
                        out_max_iter <= in_max_iter;
                        cr           <= cr_start;
                        ci           <= ci_start;
                        pixel_x      <= '0;
                        pixel_y      <= '0;
                        out_valid    <= 1'b1;
                        busy         <= 1'b1;
                        r_state      <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_handshake) begin
                        if (pixel_x < X_LAST) begin
                            pixel_x <= pixel_x + 10'd1;
                            cr      <= cr + r_dx;
                        end else if (pixel_y < Y_LAST) begin
                            pixel_x <= '0;
                            pixel_y <= pixel_y + 9'd1;
                            cr      <= r_cr_start;
                            ci      <= ci - r_dy;
                        end else begin
                            out_valid  <= 1'b0;
                            frame_done <= 1'b1;
                            r_state    <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    frame_done <= 1'b0;
                    busy       <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mandelbrot_pixel_dispatcher.sv
// Directed bench for mandelbrot_pixel_dispatcher: a 4x3 instance for the
// raster, stall, start, reset and wrap scenarios and a default 640x480
// instance for the row-end and row-restart arithmetic.
module tb_mandelbrot_pixel_dispatcher;

    logic        clk;
    logic        reset;
    logic        start;
    logic        l_start;
    logic [26:0] cr_start;
    logic [26:0] ci_start;
    logic [26:0] dx;
    logic [26:0] dy;
    logic [12:0] max_iter;
    logic        ready;
    logic        l_ready;

    logic        s_valid, s_busy, s_done;
    logic [26:0] s_cr, s_ci;
    logic [9:0]  s_x;
    logic [8:0]  s_y;
    logic [12:0] s_mi;

    logic        l_valid, l_busy, l_done;
    logic [26:0] l_cr, l_ci;
    logic [9:0]  l_x;
    logic [8:0]  l_y;
    logic [12:0] l_mi;

    int n_tests = 0;
    int n_fail  = 0;

    mandelbrot_pixel_dispatcher #(.H_RES(4), .V_RES(3), .WIDTH(27), .ITERW(13)) dut_s (
        .clk(clk), .reset(reset), .start(start),
        .cr_start(cr_start), .ci_start(ci_start), .dx(dx), .dy(dy),
        .in_max_iter(max_iter), .out_valid(s_valid), .out_ready(ready),
        .cr(s_cr), .ci(s_ci), .pixel_x(s_x), .pixel_y(s_y),
        .out_max_iter(s_mi), .busy(s_busy), .frame_done(s_done)
    );

    mandelbrot_pixel_dispatcher dut_l (
        .clk(clk), .reset(reset), .start(l_start),
        .cr_start(cr_start), .ci_start(ci_start), .dx(dx), .dy(dy),
        .in_max_iter(max_iter), .out_valid(l_valid), .out_ready(l_ready),
        .cr(l_cr), .ci(l_ci), .pixel_x(l_x), .pixel_y(l_y),
        .out_max_iter(l_mi), .busy(l_busy), .frame_done(l_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected coordinates for the 4x3 frame: cr0=-2.0, ci0=+1.0, steps 0.5.
    function automatic logic [26:0] exp_cr(input int x);
        logic [26:0] v;
        v = 27'h7000000 + 27'(x * 32'h0400000);
        return v;
    endfunction

    function automatic logic [26:0] exp_ci(input int y);
        logic [26:0] v;
        v = 27'h0800000 - 27'(y * 32'h0400000);
        return v;
    endfunction

    task automatic setup_small();
        cr_start = 27'h7000000;
        ci_start = 27'h0800000;
        dx       = 27'h0400000;
        dy       = 27'h0400000;
        max_iter = 13'd100;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic drain_small();
        int cyc;
        ready = 1'b1;
        cyc = 0;
        while (s_busy && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        n_tests++;
        if (s_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_timeout: busy=%b after %0d cycles, want 0", s_busy, cyc);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; l_start = 1'b0; ready = 1'b0; l_ready = 1'b0;
        cr_start = '0; ci_start = '0; dx = '0; dy = '0; max_iter = '0;
        #1;
        n_tests++;
        if ({s_valid, s_busy, s_done, s_cr, s_ci, s_x, s_y, s_mi, l_valid, l_busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: v=%b busy=%b done=%b cr=%h ci=%h x=%0d y=%0d mi=%0d l_v=%b, want all 0",
                     s_valid, s_busy, s_done, s_cr, s_ci, s_x, s_y, s_mi, l_valid);
        end
        @(negedge clk) reset = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({s_valid, s_busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_release_idle: v=%b busy=%b, want 0 0", s_valid, s_busy);
        end
    endtask

    task automatic test_basic();
        setup_small();
        ready = 1'b1;
        pulse_start();
        for (int k = 0; k < 12; k++) begin
            n_tests++;
            if ({s_valid, s_x, s_y, s_cr, s_ci, s_mi} !==
                {1'b1, 10'(k % 4), 9'(k / 4), exp_cr(k % 4), exp_ci(k / 4), 13'd100}) begin
                n_fail++;
                $display("FAIL basic_pix%0d: got v=%b x=%0d y=%0d cr=%h ci=%h mi=%0d, want v=1 x=%0d y=%0d cr=%h ci=%h mi=100",
                         k, s_valid, s_x, s_y, s_cr, s_ci, s_mi, k % 4, k / 4, exp_cr(k % 4), exp_ci(k / 4));
            end
            @(negedge clk);
        end
        n_tests++;
        if ({s_done, s_valid, s_busy} !== 3'b101) begin
            n_fail++;
            $display("FAIL basic_frame_done: done=%b v=%b busy=%b, want 1 0 1", s_done, s_valid, s_busy);
        end
        @(negedge clk);
        n_tests++;
        if ({s_done, s_valid, s_busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL basic_idle: done=%b v=%b busy=%b, want 0 0 0", s_done, s_valid, s_busy);
        end
    endtask

    task automatic test_stall();
        int pat [4] = '{1, 0, 0, 1};
        int k;
        int cyc;
        logic r;
        setup_small();
        ready = 1'b0;
        pulse_start();
        k = 0;
        cyc = 0;
        while (k < 12 && cyc < 100) begin
            n_tests++;
            if ({s_valid, s_x, s_y, s_cr, s_ci} !==
                {1'b1, 10'(k % 4), 9'(k / 4), exp_cr(k % 4), exp_ci(k / 4)}) begin
                n_fail++;
                $display("FAIL stall_pix%0d_cyc%0d: got v=%b x=%0d y=%0d cr=%h ci=%h, want v=1 x=%0d y=%0d cr=%h ci=%h",
                         k, cyc, s_valid, s_x, s_y, s_cr, s_ci, k % 4, k / 4, exp_cr(k % 4), exp_ci(k / 4));
            end
            r = (pat[cyc % 4] != 0);
            ready = r;
            @(negedge clk);
            if (r) k++;
            cyc++;
        end
        n_tests++;
        if (k != 12 || s_done !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_end: accepted=%0d done=%b, want 12 1", k, s_done);
        end
        ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_start_hold();
        int acc;
        int cyc;
        int extra;
        setup_small();
        ready = 1'b1;
        @(negedge clk) start = 1'b1;
        @(negedge clk);
        acc = 0;
        cyc = 0;
        while (s_done !== 1'b1 && cyc < 40) begin
            if (s_valid) acc++;
            @(negedge clk);
            cyc++;
        end
        n_tests++;
        if (acc != 12 || s_done !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_count: accepted=%0d done=%b, want 12 1", acc, s_done);
        end
        @(negedge clk) start = 1'b0;
        extra = 0;
        repeat (3) begin
            @(negedge clk);
            if (s_valid || s_busy) extra++;
        end
        n_tests++;
        if (extra != 0) begin
            n_fail++;
            $display("FAIL hold_no_second_frame: active cycles=%0d, want 0", extra);
        end
        cr_start = 27'h0000000;
        ci_start = 27'h7F00000;
        max_iter = 13'd7;
        pulse_start();
        n_tests++;
        if ({s_valid, s_x, s_y, s_cr, s_ci, s_mi} !==
            {1'b1, 10'd0, 9'd0, 27'h0000000, 27'h7F00000, 13'd7}) begin
            n_fail++;
            $display("FAIL restart_pix0: got v=%b x=%0d y=%0d cr=%h ci=%h mi=%0d, want 1 0 0 0000000 7f00000 7",
                     s_valid, s_x, s_y, s_cr, s_ci, s_mi);
        end
        drain_small();
    endtask

    task automatic test_reset_mid();
        setup_small();
        ready = 1'b1;
        pulse_start();
        repeat (6) @(negedge clk);
        n_tests++;
        if ({s_valid, s_x, s_y} !== {1'b1, 10'd2, 9'd1}) begin
            n_fail++;
            $display("FAIL midreset_position: v=%b x=%0d y=%0d, want 1 2 1", s_valid, s_x, s_y);
        end
        reset = 1'b0;
        #1;
        n_tests++;
        if ({s_valid, s_busy, s_cr, s_ci, s_x, s_y} !== '0) begin
            n_fail++;
            $display("FAIL midreset_clear: v=%b busy=%b cr=%h ci=%h x=%0d y=%0d, want all 0",
                     s_valid, s_busy, s_cr, s_ci, s_x, s_y);
        end
        @(negedge clk) reset = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({s_valid, s_busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL midreset_quiet: v=%b busy=%b, want 0 0", s_valid, s_busy);
        end
        pulse_start();
        n_tests++;
        if ({s_valid, s_x, s_y, s_cr, s_ci} !== {1'b1, 10'd0, 9'd0, 27'h7000000, 27'h0800000}) begin
            n_fail++;
            $display("FAIL midreset_restart: v=%b x=%0d y=%0d cr=%h ci=%h, want 1 0 0 7000000 0800000",
                     s_valid, s_x, s_y, s_cr, s_ci);
        end
        drain_small();
    endtask

    task automatic test_wrap();
        setup_small();
        cr_start = 27'h3FFFFFF;
        dx = 27'h0000001;
        ready = 1'b0;
        pulse_start();
        n_tests++;
        if ({s_valid, s_cr} !== {1'b1, 27'h3FFFFFF}) begin
            n_fail++;
            $display("FAIL wrap_first: v=%b cr=%h, want 1 3ffffff", s_valid, s_cr);
        end
        ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({s_valid, s_x, s_cr} !== {1'b1, 10'd1, 27'h4000000}) begin
            n_fail++;
            $display("FAIL wrap_next: v=%b x=%0d cr=%h, want 1 1 4000000", s_valid, s_x, s_cr);
        end
        drain_small();
    endtask

    task automatic test_large_row();
        int cyc;
        cr_start = 27'h7000000;
        ci_start = 27'h0800000;
        dx       = 27'h000999A;
        dy       = 27'h0010000;
        max_iter = 13'd4095;
        l_ready  = 1'b1;
        @(negedge clk) l_start = 1'b1;
        @(negedge clk) l_start = 1'b0;
        cyc = 0;
        while (!(l_valid && l_x == 10'd639) && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        n_tests++;
        if ({l_valid, l_busy, l_done, l_y, l_cr, l_ci, l_mi} !==
            {1'b1, 1'b1, 1'b0, 9'd0, 27'h07F6766, 27'h0800000, 13'd4095}) begin
            n_fail++;
            $display("FAIL large_row_end: cyc=%0d v=%b x=%0d y=%0d cr=%h ci=%h mi=%0d, want x=639 y=0 cr=07f6766 ci=0800000 mi=4095",
                     cyc, l_valid, l_x, l_y, l_cr, l_ci, l_mi);
        end
        @(negedge clk);
        n_tests++;
        if ({l_valid, l_x, l_y, l_cr, l_ci} !== {1'b1, 10'd0, 9'd1, 27'h7000000, 27'h07F0000}) begin
            n_fail++;
            $display("FAIL large_row_restart: v=%b x=%0d y=%0d cr=%h ci=%h, want 1 0 1 7000000 07f0000",
                     l_valid, l_x, l_y, l_cr, l_ci);
        end
        l_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_start_hold();
        test_reset_mid();
        test_wrap();
        test_large_row();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
